// File: rtl/led_fader.sv
// PWM LED driver that ramps brightness linearly toward the on/off target given by en.
// Optional square-law duty mapping when LED_FADER_GAMMA_EN is defined.
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {S_OFF, S_RAMP_UP, S_ON, S_RAMP_DOWN} state_t;

  state_t              r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_level, w_level_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_duty;
  logic [PW-1:0]       r_presc, w_presc_nxt;
  logic                r_led;
  logic                w_ramping;
  logic                w_tick;

  assign w_ramping = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
  assign w_tick    = w_ramping && (r_presc == PW'(STEP_DIV - 1));

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq;
  assign w_sq   = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
  assign w_duty = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty = r_level;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_presc_nxt = '0;
    // Prescaler keeps its phase across a reversal; only OFF/ON park it at 0.
    if (w_ramping) w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    case (r_state)
      S_OFF: begin
        if (en) w_state_nxt = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (!en) begin
          w_state_nxt = S_RAMP_DOWN;
        end else if (w_tick) begin
          w_level_nxt = r_level + 1'b1;
          if (r_level == MAX - 1'b1) w_state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (!en) w_state_nxt = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (en) begin
          w_state_nxt = S_RAMP_UP;
        end else if (w_tick) begin
          w_level_nxt = r_level - 1'b1;
          if (r_level == {{(PWM_BITS-1){1'b0}}, 1'b1}) w_state_nxt = S_OFF;
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_level   <= '0;
      r_pwm_cnt <= '0;
      r_presc   <= '0;
      r_led     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_presc   <= w_presc_nxt;
      r_led     <= (r_level == MAX) || (r_pwm_cnt < w_duty);
    end
  end

  assign led   = r_led;
  assign level = r_level;
  assign busy  = w_ramping;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader at PWM_BITS=4, STEP_DIV=4: per-cycle model compare plus directed checks.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       led;
  logic [3:0] level;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  led_fader #(.PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .led   (led),
    .level (level),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Model: brightness walks one step per 4 cycles toward the target,
  // a change of target while moving flips direction without stepping.
  int m_level = 0;
  int m_dir   = 0;
  int m_cnt   = 0;
  int m_cyc   = 0;
  bit m_led   = 1'b0;
  bit chk_on  = 1'b0;

  function automatic int duty_of(input int l);
`ifdef LED_FADER_GAMMA_EN
    return (l * l) / 16;
`else
    return l;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_level = 0; m_dir = 0; m_cnt = 0; m_cyc = 0; m_led = 1'b0;
    end else begin
      int want;
      bit step_due;
      m_led = (m_level == 15) || ((m_cyc % 16) < duty_of(m_level));
      m_cyc = m_cyc + 1;
      want  = en ? 1 : -1;
      if (m_dir == 0) begin
        if ((m_level == 0 && en) || (m_level == 15 && !en)) begin
          m_dir = want;
          m_cnt = 0;
        end
      end else begin
        m_cnt    = m_cnt + 1;
        step_due = (m_cnt == 4);
        if (step_due) m_cnt = 0;
        if (want != m_dir) begin
          m_dir = want;
        end else if (step_due) begin
          m_level = m_level + m_dir;
          if (m_level == 0 || m_level == 15) m_dir = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_level", 32'(level), 32'(m_level));
      check("model_led",   32'(led),   32'(m_led));
      check("model_busy",  32'(busy),  32'(m_dir != 0));
    end
  end

  task automatic wait_level(input int tgt, input int budget, output int n);
    n = 0;
    while (level !== 4'(tgt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (level !== 4'(tgt)) check("wait_level_timeout", 32'(level), 32'(tgt));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic count_led(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (led === 1'b1) highs++;
    end
  endtask

  initial begin
    int n;
    int highs;
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_led",   32'(led),   32'd0);

    // Release reset with en high: ramp up starts on the first edge.
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_level(15, 100, n);
    check("ramp_up_cycles", 32'(n), 32'd60);
    check("on_busy", 32'(busy), 32'd0);
    count_led(20, highs);
    check("on_led_highs", 32'(highs), 32'd20);

    // Full ramp down from ON.
    en = 1'b0;
    @(negedge clk);
    check("down_busy", 32'(busy), 32'd1);
    wait_level(0, 100, n);
    check("ramp_down_cycles", 32'(n), 32'd60);
    count_led(20, highs);
    check("off_led_highs", 32'(highs), 32'd0);

    // Reversal at level 6.
    en = 1'b1;
    wait_level(6, 100, n);
    en = 1'b0;
    @(negedge clk);
    check("rev_hold_level", 32'(level), 32'd6);
    check("rev_busy", 32'(busy), 32'd1);
    wait_idle(100);
    check("rev_end_level", 32'(level), 32'd0);

    // Frozen-level duty check via en toggling every cycle.
    en = 1'b1;
`ifdef LED_FADER_GAMMA_EN
    wait_level(8, 100, n);
`else
    wait_level(5, 100, n);
`endif
    for (int i = 0; i < 16; i++) begin
      en = ~en;
      @(negedge clk);
    end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      en = ~en;
      @(negedge clk);
      if (led === 1'b1) highs++;
    end
`ifdef LED_FADER_GAMMA_EN
    check("frozen_level", 32'(level), 32'd8);
    check("gamma_duty_highs", 32'(highs), 32'd4);
`else
    check("frozen_level", 32'(level), 32'd5);
    check("linear_duty_highs", 32'(highs), 32'd5);
`endif

    // Full brightness must be a constant high regardless of duty mapping.
    en = 1'b1;
    wait_idle(200);
    check("max_level", 32'(level), 32'd15);
    @(negedge clk);
    count_led(16, highs);
    check("max_led_highs", 32'(highs), 32'd16);

    // Reset mid-ramp aborts at once.
    en = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midramp_rst_level", 32'(level), 32'd0);
    check("midramp_rst_busy",  32'(busy),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
